// File: rtl/ippcsge_an_ctl.sv
// ippcsge_an_ctl: 1000BASE-X auto-negotiation arbitration controller for the
// GE PCS transmit path. It qualifies partner config codewords and idles from
// the PCS receiver, sequences link-up, and drives xmit / tx_cfdata into the
// PCS transmitter.
//
// Ports:
//   sclk125      125 MHz PCS clock (only clock)
//   rst_         synchronous active-low reset
//   an_en        auto-negotiation enable (quasi-static)
//   an_restart   one-cycle restart pulse
//   adv_ability  local advertised ability (bit14 replaced by this block)
//   sync_ok      receiver code-group sync acquired
//   rx_cfg_vld   one-cycle pulse, rx_cfdata holds a received config codeword
//   rx_cfdata    received config codeword
//   rx_idle_vld  one-cycle pulse, one /I/ ordered set received
//   xmit         0 = IDLE, 1 = CONFIG, 2 = DATA
//   tx_cfdata    config codeword to the transmitter
//   an_complete  high only in LINK_OK
//   lp_ability   latched link-partner ability
//   an_state     current state encoding
module ippcsge_an_ctl #(
    parameter int unsigned LINK_TIMER = 1250000,
    parameter int unsigned TMR_W      = 21
) (
    input  logic        sclk125,
    input  logic        rst_,
    input  logic        an_en,
    input  logic        an_restart,
    input  logic [15:0] adv_ability,
    input  logic        sync_ok,
    input  logic        rx_cfg_vld,
    input  logic [15:0] rx_cfdata,
    input  logic        rx_idle_vld,
    output logic [1:0]  xmit,
    output logic [15:0] tx_cfdata,
    output logic        an_complete,
    output logic [15:0] lp_ability,
    output logic [2:0]  an_state
);

    localparam logic [TMR_W-1:0] TMR_LAST    = TMR_W'(LINK_TIMER - 1);
    localparam logic [1:0]       XMIT_IDLE   = 2'd0;
    localparam logic [1:0]       XMIT_CONFIG = 2'd1;
    localparam logic [1:0]       XMIT_DATA   = 2'd2;

    typedef enum logic [2:0] {
        AN_ENABLE       = 3'd0,
        AN_RESTART      = 3'd1,
        ABILITY_DETECT  = 3'd2,
        ACK_DETECT      = 3'd3,
        COMPLETE_ACK    = 3'd4,
        IDLE_DETECT     = 3'd5,
        LINK_OK         = 3'd6,
        DISABLE_LINK_OK = 3'd7
    } state_e;

    state_e            state_q, state_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic [1:0]        abl_cnt_q, abl_cnt_d;
    logic [1:0]        idle_cnt_q, idle_cnt_d;
    logic [15:0]       prev_cw_q, prev_cw_d;
    logic [2:0]        ack_hist_q, ack_hist_d;
    logic [15:0]       lp_q, lp_d;
    logic              an_en_q;
    logic [1:0]        xmit_q, xmit_d;
    logic [15:0]       tx_q, tx_d;
    logic              cmpl_q, cmpl_d;
    logic              timer_rst;

    logic timer_done, ability_match, ack_match, idle_match, rx_zero;
    logic cw_nz, cw_eq, an_en_fall, an_en_rise;

    // Codeword compare ignores the ACK bit (bit14).
    function automatic logic [14:0] mask14(input logic [15:0] v);
        return {v[15], v[13:0]};
    endfunction

    assign timer_done    = (timer_q == TMR_LAST);
    assign ability_match = (abl_cnt_q == 2'd3);
    assign ack_match     = ability_match && (&ack_hist_q);
    assign idle_match    = (idle_cnt_q == 2'd3);
    assign cw_nz         = (rx_cfdata != 16'h0000);
    assign cw_eq         = (mask14(rx_cfdata) == mask14(prev_cw_q));
    assign rx_zero       = rx_cfg_vld && !cw_nz;
    assign an_en_fall    = an_en_q && !an_en;
    assign an_en_rise    = !an_en_q && an_en;

    // State and datapath register.
    always_ff @(posedge sclk125) begin
        if (!rst_) begin
            state_q    <= AN_ENABLE;
            timer_q    <= '0;
            abl_cnt_q  <= '0;
            idle_cnt_q <= '0;
            prev_cw_q  <= '0;
            ack_hist_q <= '0;
            lp_q       <= '0;
            an_en_q    <= 1'b0;
            xmit_q     <= XMIT_CONFIG;
            tx_q       <= '0;
            cmpl_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            abl_cnt_q  <= abl_cnt_d;
            idle_cnt_q <= idle_cnt_d;
            prev_cw_q  <= prev_cw_d;
            ack_hist_q <= ack_hist_d;
            lp_q       <= lp_d;
            an_en_q    <= an_en;
            xmit_q     <= xmit_d;
            tx_q       <= tx_d;
            cmpl_q     <= cmpl_d;
        end
    end

    // Consistency and idle counters; a config codeword always clears the idle run.
    always_comb begin
        abl_cnt_d  = abl_cnt_q;
        idle_cnt_d = idle_cnt_q;
        prev_cw_d  = prev_cw_q;
        ack_hist_d = ack_hist_q;
        if (rx_cfg_vld) begin
            prev_cw_d  = rx_cfdata;
            ack_hist_d = {ack_hist_q[1:0], rx_cfdata[14]};
            idle_cnt_d = '0;
            if (!cw_nz) begin
                abl_cnt_d = '0;
            end else if (cw_eq) begin
                abl_cnt_d = ability_match ? abl_cnt_q : abl_cnt_q + 2'd1;
            end else begin
                abl_cnt_d = 2'd1;
            end
        end else if (rx_idle_vld && !idle_match) begin
            idle_cnt_d = idle_cnt_q + 2'd1;
        end
        if (an_restart) begin
            abl_cnt_d  = '0;
            idle_cnt_d = '0;
        end
    end

    // Link timer: restart on selected state entries, otherwise saturate.
    always_comb begin
        timer_d = timer_q;
        if (timer_rst) begin
            timer_d = '0;
        end else if (!timer_done) begin
            timer_d = timer_q + TMR_W'(1);
        end
    end

    // Next-state logic; global overrides take precedence over per-state arcs.
    always_comb begin
        state_d   = state_q;
        timer_rst = 1'b0;
        lp_d      = lp_q;
        if (an_restart) begin
            state_d = AN_ENABLE;
        end else if (an_en && !sync_ok) begin
            state_d = AN_ENABLE;
        end else if (an_en_fall && (state_q != DISABLE_LINK_OK)) begin
            state_d = AN_ENABLE;
        end else begin
            case (state_q)
                AN_ENABLE: begin
                    if (an_en) begin
                        state_d   = AN_RESTART;
                        timer_rst = 1'b1;
                    end else begin
                        state_d = DISABLE_LINK_OK;
                    end
                end
                AN_RESTART: begin
                    if (timer_done) state_d = ABILITY_DETECT;
                end
                ABILITY_DETECT: begin
                    if (ability_match) begin
                        lp_d    = prev_cw_q;
                        state_d = ACK_DETECT;
                    end
                end
                ACK_DETECT: begin
                    if (ack_match && (prev_cw_q[13:0] == lp_q[13:0])) begin
                        state_d   = COMPLETE_ACK;
                        timer_rst = 1'b1;
                    end else if (ack_match || rx_zero) begin
                        state_d = AN_ENABLE;
                    end
                end
                COMPLETE_ACK: begin
                    if (rx_zero) begin
                        state_d = AN_ENABLE;
                    end else if (timer_done) begin
                        state_d   = IDLE_DETECT;
                        timer_rst = 1'b1;
                    end
                end
                IDLE_DETECT: begin
                    if (rx_zero) begin
                        state_d = AN_ENABLE;
                    end else if (timer_done && idle_match) begin
                        state_d = LINK_OK;
                    end
                end
                LINK_OK: begin
                    if (rx_zero || (ability_match && (mask14(prev_cw_q) != mask14(lp_q)))) begin
                        state_d = AN_ENABLE;
                    end
                end
                DISABLE_LINK_OK: begin
                    if (an_en_rise) state_d = AN_ENABLE;
                end
                default: state_d = AN_ENABLE;
            endcase
        end
    end

    // Moore output decode, taken from the next state so the flops track the state register.
    always_comb begin
        xmit_d = XMIT_CONFIG;
        tx_d   = '0;
        cmpl_d = 1'b0;
        case (state_d)
            ABILITY_DETECT:             tx_d = {adv_ability[15], 1'b0, adv_ability[13:0]};
            ACK_DETECT, COMPLETE_ACK:   tx_d = {adv_ability[15], 1'b1, adv_ability[13:0]};
            IDLE_DETECT:                xmit_d = XMIT_IDLE;
            LINK_OK: begin
                xmit_d = XMIT_DATA;
                cmpl_d = 1'b1;
            end
            DISABLE_LINK_OK:            xmit_d = XMIT_DATA;
            default: begin
                xmit_d = XMIT_CONFIG;
                tx_d   = '0;
            end
        endcase
    end

    assign xmit        = xmit_q;
    assign tx_cfdata   = tx_q;
    assign an_complete = cmpl_q;
    assign lp_ability  = lp_q;
    assign an_state    = state_q;

endmodule

// File: tb/tb_ippcsge_an_ctl.sv
// Bench for ippcsge_an_ctl: directed link-up scenarios followed by random
// stimulus, checked against a behavioural model through a scoreboard queue.
module tb_ippcsge_an_ctl;

    localparam int LT = 16;

    localparam int S_EN   = 0;
    localparam int S_RST  = 1;
    localparam int S_ABL  = 2;
    localparam int S_ACK  = 3;
    localparam int S_CACK = 4;
    localparam int S_IDLE = 5;
    localparam int S_OK   = 6;
    localparam int S_DIS  = 7;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        an_en;
    logic        an_restart;
    logic [15:0] adv;
    logic        sync_ok;
    logic        cfg_vld;
    logic [15:0] cfdata;
    logic        idle_vld;
    logic [1:0]  xmit;
    logic [15:0] tx_cfdata;
    logic        an_complete;
    logic [15:0] lp_ability;
    logic [2:0]  an_state;

    always #5 clk = ~clk;

    ippcsge_an_ctl #(.LINK_TIMER(LT), .TMR_W(5)) dut (
        .sclk125     (clk),
        .rst_        (rst_n),
        .an_en       (an_en),
        .an_restart  (an_restart),
        .adv_ability (adv),
        .sync_ok     (sync_ok),
        .rx_cfg_vld  (cfg_vld),
        .rx_cfdata   (cfdata),
        .rx_idle_vld (idle_vld),
        .xmit        (xmit),
        .tx_cfdata   (tx_cfdata),
        .an_complete (an_complete),
        .lp_ability  (lp_ability),
        .an_state    (an_state)
    );

    typedef struct packed {
        logic [2:0]  st;
        logic [1:0]  xm;
        logic [15:0] tx;
        logic        cmpl;
        logic [15:0] lp;
    } obs_t;

    obs_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    // Behavioural model state: received codewords since the last restart.
    int          m_st;
    int          m_tmr;
    logic [15:0] m_cws[$];
    int          m_idles;
    logic [15:0] m_lp;
    logic        m_en_prev;

    function automatic logic [14:0] msk(input logic [15:0] v);
        return {v[15], v[13:0]};
    endfunction

    // Last three codewords nonzero and identical apart from the ACK bit.
    function automatic bit f_abl();
        int n;
        n = m_cws.size();
        if (n < 3) return 1'b0;
        return (m_cws[n-1] != 0) && (m_cws[n-2] != 0) && (m_cws[n-3] != 0) &&
               (msk(m_cws[n-1]) == msk(m_cws[n-2])) && (msk(m_cws[n-2]) == msk(m_cws[n-3]));
    endfunction

    function automatic bit f_ack();
        int n;
        n = m_cws.size();
        if (!f_abl()) return 1'b0;
        return m_cws[n-1][14] && m_cws[n-2][14] && m_cws[n-3][14];
    endfunction

    function automatic obs_t m_obs();
        obs_t o;
        o.st   = 3'(m_st);
        o.xm   = 2'd1;
        o.tx   = 16'h0000;
        o.cmpl = 1'b0;
        o.lp   = m_lp;
        case (m_st)
            S_ABL:         o.tx = adv & 16'hBFFF;
            S_ACK, S_CACK: o.tx = adv | 16'h4000;
            S_IDLE:        o.xm = 2'd0;
            S_OK: begin
                o.xm   = 2'd2;
                o.cmpl = 1'b1;
            end
            S_DIS:         o.xm = 2'd2;
            default:       o.tx = 16'h0000;
        endcase
        return o;
    endfunction

    task automatic model_step();
        bit          abl, ack, done, rxz, trst;
        int          nst;
        logic [15:0] last;
        if (!rst_n) begin
            m_st = S_EN; m_tmr = 0; m_cws.delete(); m_idles = 0; m_lp = 16'h0; m_en_prev = 1'b0;
            return;
        end
        abl  = f_abl();
        ack  = f_ack();
        done = (m_tmr == LT - 1);
        rxz  = cfg_vld && (cfdata == 16'h0000);
        last = (m_cws.size() > 0) ? m_cws[m_cws.size()-1] : 16'h0000;
        nst  = m_st;
        trst = 1'b0;
        if (an_restart) nst = S_EN;
        else if (an_en && !sync_ok) nst = S_EN;
        else if (m_en_prev && !an_en && m_st != S_DIS) nst = S_EN;
        else begin
            case (m_st)
                S_EN:   if (an_en) begin nst = S_RST; trst = 1'b1; end else nst = S_DIS;
                S_RST:  if (done) nst = S_ABL;
                S_ABL:  if (abl) begin m_lp = last; nst = S_ACK; end
                S_ACK:  if (ack && last[13:0] == m_lp[13:0]) begin nst = S_CACK; trst = 1'b1; end
                        else if (ack || rxz) nst = S_EN;
                S_CACK: if (rxz) nst = S_EN; else if (done) begin nst = S_IDLE; trst = 1'b1; end
                S_IDLE: if (rxz) nst = S_EN; else if (done && m_idles >= 3) nst = S_OK;
                S_OK:   if (rxz || (abl && msk(last) != msk(m_lp))) nst = S_EN;
                default: if (!m_en_prev && an_en) nst = S_EN;
            endcase
        end
        if (trst) m_tmr = 0;
        else if (m_tmr < LT - 1) m_tmr++;
        if (cfg_vld) begin
            m_cws.push_back(cfdata);
            if (m_cws.size() > 3) void'(m_cws.pop_front());
            m_idles = 0;
        end else if (idle_vld) begin
            m_idles++;
        end
        if (an_restart) begin
            m_cws.delete();
            m_idles = 0;
        end
        m_en_prev = an_en;
        m_st      = nst;
    endtask

    // Issue one cycle of stimulus and queue the expected post-edge outputs.
    task automatic tick();
        model_step();
        exp_q.push_back(m_obs());
        @(negedge clk);
        cyc++;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic send_cw(input logic [15:0] v);
        cfg_vld = 1'b1; cfdata = v; tick();
        cfg_vld = 1'b0; tick();
    endtask

    task automatic send_idle();
        idle_vld = 1'b1; tick();
        idle_vld = 1'b0; tick();
    endtask

    // Monitor: compares the DUT outputs after every clock edge.
    initial begin : monitor
        obs_t e, got;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                got = {an_state, xmit, tx_cfdata, an_complete, lp_ability};
                checks++;
                if (got !== e) begin
                    errors++;
                    $display("FAIL outputs t=%0t got st=%0d xmit=%0d tx=%h cmpl=%b lp=%h exp st=%0d xmit=%0d tx=%h cmpl=%b lp=%h",
                             $time, got.st, got.xm, got.tx, got.cmpl, got.lp,
                             e.st, e.xm, e.tx, e.cmpl, e.lp);
                end
            end
        end
    end

    initial begin : stim
        int          phase;
        int          r;
        logic [15:0] pw;
        rst_n = 1'b0; an_en = 1'b1; an_restart = 1'b0; adv = 16'h01A0;
        sync_ok = 1'b1; cfg_vld = 1'b0; cfdata = 16'h0; idle_vld = 1'b0;
        ticks(3);
        rst_n = 1'b1;
        // Link-up: restart period, abilities, acks, idles.
        ticks(20);
        repeat (3) send_cw(16'h41A0);
        ticks(2);
        repeat (3) send_cw(16'h41A0);
        ticks(20);
        repeat (3) send_idle();
        ticks(4);
        // Partner sends a zero codeword in LINK_OK.
        send_cw(16'h0000);
        ticks(22);
        // Non-acking abilities, then inconsistent acks.
        repeat (3) send_cw(16'h01A0);
        ticks(3);
        repeat (3) send_cw(16'h4020);
        ticks(40);
        // Sync loss in IDLE_DETECT, then recovery to LINK_OK.
        sync_ok = 1'b0; ticks(5);
        sync_ok = 1'b1; ticks(60);
        repeat (3) send_idle();
        ticks(4);
        an_restart = 1'b1; tick();
        an_restart = 1'b0; ticks(4);
        // an_en falling mid-negotiation.
        an_en = 1'b0; ticks(3);
        an_en = 1'b1; ticks(5);
        // Disabled from reset, then reset mid-operation.
        rst_n = 1'b0; an_en = 1'b0; ticks(2);
        rst_n = 1'b1; ticks(5);
        an_en = 1'b1; ticks(25);
        repeat (3) send_cw(16'h41A0);
        ticks(3);
        rst_n = 1'b0; tick();
        rst_n = 1'b1; ticks(3);
        // Random phase.
        adv   = 16'hC1A5;
        phase = 0;
        pw    = 16'h41A0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 59) == 0) phase = $urandom_range(0, 2);
            if ($urandom_range(0, 79) == 0) begin
                case ($urandom_range(0, 3))
                    0:       pw = 16'h01A0;
                    1:       pw = 16'h41A0;
                    2:       pw = 16'h4020;
                    default: pw = 16'($urandom());
                endcase
            end
            rst_n      = ($urandom_range(0, 799) != 0);
            an_restart = ($urandom_range(0, 399) == 0);
            if (sync_ok && $urandom_range(0, 299) == 0) sync_ok = 1'b0;
            else if (!sync_ok && $urandom_range(0, 19) == 0) sync_ok = 1'b1;
            if (an_en && $urandom_range(0, 499) == 0) an_en = 1'b0;
            else if (!an_en && $urandom_range(0, 59) == 0) an_en = 1'b1;
            r = $urandom_range(0, 19);
            cfdata   = (r < 14) ? pw : (r < 17) ? (pw ^ 16'h4000) : (r < 18) ? 16'h0000 : 16'($urandom());
            cfg_vld  = 1'b0;
            idle_vld = 1'b0;
            case (phase)
                0:       cfg_vld = ($urandom_range(0, 2) == 0);
                1: begin
                    idle_vld = ($urandom_range(0, 2) == 0);
                    cfg_vld  = ($urandom_range(0, 49) == 0);
                end
                default: begin
                    cfg_vld  = ($urandom_range(0, 2) == 0);
                    idle_vld = ($urandom_range(0, 2) == 0);
                end
            endcase
            tick();
        end
        cfg_vld = 1'b0; idle_vld = 1'b0; an_restart = 1'b0;
        ticks(2);
        @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
